// File: rtl/lcd_ctrl.sv
// lcd_ctrl: write-only controller for an HD44780-style character LCD.
// Accepts bytes on a valid/ready interface and strobes them onto a 4- or
// 8-bit LCD bus with setup, enable-pulse, hold and execution-time delays.
// Build option LCD_INIT_EN: when defined, the controller runs the power-up
// init sequence itself before accepting bytes; when undefined it starts in
// IDLE and the host issues the init commands through the byte interface.
//
// state | meaning
// PWRUP | power-on delay before the first init write
// INIT  | launch the next write of the init sequence
// IDLE  | waiting for a host byte
// SETUP | lcd_rs/lcd_db driven, lcd_e low
// PULSE | lcd_e high
// GAP   | hold cycle plus inter-nibble gap (4-bit bus only)
// WAIT  | hold cycle plus command execution time
module lcd_ctrl #(
  parameter int BUS_W   = 4,
  parameter int T_PWRUP = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 12,
  parameter int T_NIB   = 50,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_rs,
  input  logic [7:0]       in_data,
  output logic             init_done,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic [BUS_W-1:0] lcd_db
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

`ifdef LCD_INIT_EN
  localparam int MAX_T = max2(max2(max2(T_PWRUP, T_INIT1), T_INIT2),
                              max2(max2(T_SETUP, T_PULSE), max2(max2(T_NIB, T_CMD), T_CLR)));
`else
  localparam int MAX_T = max2(max2(T_SETUP, T_PULSE), max2(max2(T_NIB, T_CMD), T_CLR));
`endif
  localparam int CW = $clog2(MAX_T + 1);

  if (BUS_W != 4 && BUS_W != 8) begin : g_bus_chk
    $error("lcd_ctrl: BUS_W must be 4 or 8");
  end
  if (T_PWRUP < 2 || T_INIT1 < 1 || T_INIT2 < 1 || T_SETUP < 1 ||
      T_PULSE < 1 || T_NIB < 1 || T_CMD < 1 || T_CLR < 1) begin : g_time_chk
    $error("lcd_ctrl: timing parameter out of range");
  end

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, PULSE, GAP, WAIT} state_t;

`ifdef LCD_INIT_EN
  localparam state_t RST_STATE = PWRUP;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  // Clear display (0x01) and return home (0x02/0x03) take the long delay.
  function automatic logic [CW-1:0] exec_time(input logic rs, input logic [7:0] b);
    return (!rs && b[7:2] == 6'd0) ? CW'(T_CLR) : CW'(T_CMD);
  endfunction

  // Upper nibble on a 4-bit bus, whole byte on an 8-bit bus.
  function automatic logic [BUS_W-1:0] first_part(input logic [7:0] b);
    return BUS_W'(b >> (8 - BUS_W));
  endfunction

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  wait_q;
  logic [7:0]     byte_q;
  logic           second_q;
  logic           more_nib;

  assign lcd_rw = 1'b0;

`ifdef LCD_INIT_EN
  localparam logic [3:0] N_STEPS = (BUS_W == 8) ? 4'd7 : 4'd8;

  logic           done_q;
  logic           armed;
  logic           single_q;
  logic [3:0]     step;
  logic [3:0]     step_eff;
  logic [7:0]     init_byte;
  logic           init_single;
  logic [CW-1:0]  init_wait;

  assign init_done = done_q;
  assign more_nib  = (BUS_W == 4) && !single_q && !second_q;

  // Init sequence table; the 8-bit build skips the 0x2 bus-width nibble.
  always_comb begin
    step_eff    = (BUS_W == 8 && step >= 4'd3) ? step + 4'd1 : step;
    init_byte   = 8'h01;
    init_single = 1'b0;
    init_wait   = CW'(T_CMD);
    case (step_eff)
      4'd0: begin init_byte = 8'h30; init_single = 1'b1; init_wait = CW'(T_INIT1); end
      4'd1: begin init_byte = 8'h30; init_single = 1'b1; init_wait = CW'(T_INIT2); end
      4'd2: begin init_byte = 8'h30; init_single = 1'b1; init_wait = CW'(T_CMD);   end
      4'd3: begin init_byte = 8'h20; init_single = 1'b1; init_wait = CW'(T_CMD);   end
      4'd4: init_byte = (BUS_W == 8) ? 8'h38 : 8'h28;
      4'd5: init_byte = 8'h06;
      4'd6: init_byte = 8'h0C;
      default: init_byte = 8'h01;
    endcase
    if (!init_single) init_wait = exec_time(1'b0, init_byte);
  end
`else
  assign init_done = 1'b1;
  assign more_nib  = (BUS_W == 4) && !second_q;
`endif

  // Main sequencer: one down-counter times every state, outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RST_STATE;
      cnt      <= '0;
      wait_q   <= '0;
      byte_q   <= 8'h00;
      second_q <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_db   <= '0;
      in_ready <= 1'b0;
`ifdef LCD_INIT_EN
      done_q   <= 1'b0;
      armed    <= 1'b0;
      single_q <= 1'b0;
      step     <= 4'd0;
`endif
    end else begin
      case (state)
`ifdef LCD_INIT_EN
        PWRUP: begin
          // First cycle loads the counter since reset leaves it at zero.
          if (!armed) begin
            cnt   <= CW'(T_PWRUP - 2);
            armed <= 1'b1;
          end else if (cnt == '0) begin
            state <= INIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        INIT: begin
          byte_q   <= init_byte;
          single_q <= init_single;
          wait_q   <= init_wait;
          second_q <= 1'b0;
          lcd_rs   <= 1'b0;
          lcd_db   <= first_part(init_byte);
          cnt      <= CW'(T_SETUP - 1);
          step     <= step + 4'd1;
          state    <= SETUP;
        end
`endif
        IDLE: begin
          if (in_valid && in_ready) begin
            byte_q   <= in_data;
            wait_q   <= exec_time(in_rs, in_data);
            second_q <= 1'b0;
`ifdef LCD_INIT_EN
            single_q <= 1'b0;
`endif
            lcd_rs   <= in_rs;
            lcd_db   <= first_part(in_data);
            cnt      <= CW'(T_SETUP - 1);
            in_ready <= 1'b0;
            state    <= SETUP;
          end else begin
            in_ready <= init_done;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= CW'(T_PULSE - 1);
            state <= PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE: begin
          // GAP/WAIT load T rather than T-1: their first cycle is the hold cycle.
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            if (more_nib) begin
              cnt   <= CW'(T_NIB);
              state <= GAP;
            end else begin
              cnt   <= wait_q;
              state <= WAIT;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            second_q <= 1'b1;
            lcd_db   <= BUS_W'(byte_q);
            cnt      <= CW'(T_SETUP - 1);
            state    <= SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
`ifdef LCD_INIT_EN
            if (done_q || step == N_STEPS) begin
              done_q   <= 1'b1;
              in_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= INIT;
            end
`else
            in_ready <= 1'b1;
            state    <= IDLE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= RST_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed bench for lcd_ctrl with a 4-bit and an 8-bit instance
// sharing clock, reset and byte inputs. A negedge monitor records every lcd_e
// rise and fall with the bus value and cycle number; tasks compare those
// against hand-computed strobe values and delays.
module tb_lcd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LCD_INIT_EN
  localparam logic INIT_BUILD = 1'b1;
`else
  localparam logic INIT_BUILD = 1'b0;
`endif

  localparam logic [8:0] INIT4 [12] = '{9'h003, 9'h003, 9'h003, 9'h002, 9'h002, 9'h008,
                                        9'h000, 9'h006, 9'h000, 9'h00C, 9'h000, 9'h001};
  localparam logic [8:0] INIT8 [7]  = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h006, 9'h00C, 9'h001};

  logic       rst_n = 1'b0;
  logic       v4 = 1'b0, v8 = 1'b0, rs_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       rdy4, done4, e4, rs4, rw4;
  logic [3:0] db4;
  logic       rdy8, done8, e8, rs8, rw8;
  logic [7:0] db8;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int rw_bad = 0;
  logic e4_d = 1'b0, e8_d = 1'b0;
  logic [8:0] r4_q[$], f4_q[$], r8_q[$], f8_q[$];
  int         r4_t[$], f4_t[$], r8_t[$], f8_t[$];

  lcd_ctrl #(.BUS_W(4), .T_PWRUP(20), .T_INIT1(10), .T_INIT2(5), .T_SETUP(2),
             .T_PULSE(3), .T_NIB(4), .T_CMD(6), .T_CLR(15)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_rs(rs_i),
    .in_data(data_i), .init_done(done4), .lcd_e(e4), .lcd_rs(rs4), .lcd_rw(rw4),
    .lcd_db(db4));

  lcd_ctrl #(.BUS_W(8), .T_PWRUP(20), .T_INIT1(10), .T_INIT2(5), .T_SETUP(2),
             .T_PULSE(3), .T_NIB(4), .T_CMD(6), .T_CLR(15)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_rs(rs_i),
    .in_data(data_i), .init_done(done8), .lcd_e(e8), .lcd_rs(rs8), .lcd_rw(rw8),
    .lcd_db(db8));

  // Cycle counter for delay measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (e4 && !e4_d) begin r4_q.push_back({4'd0, rs4, db4}); r4_t.push_back(cyc); end
    if (!e4 && e4_d) begin f4_q.push_back({4'd0, rs4, db4}); f4_t.push_back(cyc); end
    if (e8 && !e8_d) begin r8_q.push_back({rs8, db8}); r8_t.push_back(cyc); end
    if (!e8 && e8_d) begin f8_q.push_back({rs8, db8}); f8_t.push_back(cyc); end
    if (rw4 || rw8) rw_bad <= rw_bad + 1;
    e4_d <= e4;
    e8_d <= e8;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_q();
    r4_q.delete(); f4_q.delete(); r4_t.delete(); f4_t.delete();
    r8_q.delete(); f8_q.delete(); r8_t.delete(); f8_t.delete();
  endtask

  task automatic wait_rdy(input bit eight, output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((eight ? rdy8 : rdy4) == 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  // One host byte through the 4-bit instance; poke scrambles inputs mid-transfer.
  task automatic xfer4(input string tag, input logic rs, input logic [7:0] d,
                       input bit poke, input int exp_wait);
    int t_rdy;
    logic [8:0] n0, n1;
    n0 = {4'd0, rs, d[7:4]};
    n1 = {4'd0, rs, d[3:0]};
    @(negedge clk);
    clr_q();
    chk({tag, "_rdy_pre"}, 32'(rdy4), 32'd1);
    rs_i = rs; data_i = d; v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    chk({tag, "_rdy_drop"}, 32'(rdy4), 32'd0);
    if (poke) begin
      data_i = 8'hFF;
      rs_i = ~rs;
    end
    wait_rdy(1'b0, t_rdy);
    chk({tag, "_timeout"}, 32'(t_rdy >= 0), 32'd1);
    chk({tag, "_nstrobe"}, 32'(r4_q.size()), 32'd2);
    if (r4_q.size() == 2 && f4_q.size() == 2) begin
      chk({tag, "_nib0"}, 32'(r4_q[0]), 32'(n0));
      chk({tag, "_nib1"}, 32'(r4_q[1]), 32'(n1));
      chk({tag, "_hold0"}, 32'(f4_q[0]), 32'(n0));
      chk({tag, "_hold1"}, 32'(f4_q[1]), 32'(n1));
      chk({tag, "_hi0"}, 32'(f4_t[0] - r4_t[0]), 32'd3);
      chk({tag, "_hi1"}, 32'(f4_t[1] - r4_t[1]), 32'd3);
      chk({tag, "_gap"}, 32'(r4_t[1] - f4_t[0]), 32'd7);
      chk({tag, "_post"}, 32'(t_rdy - f4_t[1]), 32'(exp_wait + 1));
    end
  endtask

  task automatic xfer8(input string tag, input logic rs, input logic [7:0] d, input int exp_wait);
    int t_rdy;
    logic [8:0] n0;
    n0 = {rs, d};
    @(negedge clk);
    clr_q();
    chk({tag, "_rdy_pre"}, 32'(rdy8), 32'd1);
    rs_i = rs; data_i = d; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    chk({tag, "_rdy_drop"}, 32'(rdy8), 32'd0);
    wait_rdy(1'b1, t_rdy);
    chk({tag, "_timeout"}, 32'(t_rdy >= 0), 32'd1);
    chk({tag, "_nstrobe"}, 32'(r8_q.size()), 32'd1);
    if (r8_q.size() == 1 && f8_q.size() == 1) begin
      chk({tag, "_byte"}, 32'(r8_q[0]), 32'(n0));
      chk({tag, "_hold"}, 32'(f8_q[0]), 32'(n0));
      chk({tag, "_hi"}, 32'(f8_t[0] - r8_t[0]), 32'd3);
      chk({tag, "_post"}, 32'(t_rdy - f8_t[0]), 32'(exp_wait + 1));
    end
  endtask

  // Built-in init sequence on both instances, started from a reset release.
  task automatic init_check(input string tag);
    int t4, t8;
    logic d4, d8;
    t4 = -1; t8 = -1; d4 = 1'b0; d8 = 1'b0;
    for (int i = 0; i < 1500 && (t4 < 0 || t8 < 0); i++) begin
      @(negedge clk);
      if (t4 < 0 && rdy4) begin t4 = cyc; d4 = done4; end
      if (t8 < 0 && rdy8) begin t8 = cyc; d8 = done8; end
    end
    chk({tag, "_timeout4"}, 32'(t4 >= 0), 32'd1);
    chk({tag, "_timeout8"}, 32'(t8 >= 0), 32'd1);
    chk({tag, "_done4"}, 32'(d4), 32'd1);
    chk({tag, "_done8"}, 32'(d8), 32'd1);
    chk({tag, "_n4"}, 32'(r4_q.size()), 32'd12);
    chk({tag, "_n8"}, 32'(r8_q.size()), 32'd7);
    for (int i = 0; i < 12; i++)
      if (i < r4_q.size()) chk($sformatf("%s_nib4_%0d", tag, i), 32'(r4_q[i]), 32'(INIT4[i]));
    for (int i = 0; i < 7; i++)
      if (i < r8_q.size()) chk($sformatf("%s_byte8_%0d", tag, i), 32'(r8_q[i]), 32'(INIT8[i]));
    if (r4_q.size() >= 2) chk({tag, "_t_init1_4"}, 32'(r4_t[1] - r4_t[0]), 32'd17);
    if (r8_q.size() >= 2) chk({tag, "_t_init1_8"}, 32'(r8_t[1] - r8_t[0]), 32'd17);
    if (f4_t.size() >= 1) chk({tag, "_t_clr4"}, 32'(t4 - f4_t[f4_t.size() - 1]), 32'd16);
    if (f8_t.size() >= 1) chk({tag, "_t_clr8"}, 32'(t8 - f8_t[f8_t.size() - 1]), 32'd16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "tb_lcd_ctrl watchdog");
  end

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    chk("rst_e4", 32'(e4), 32'd0);
    chk("rst_rs4", 32'(rs4), 32'd0);
    chk("rst_rw4", 32'(rw4), 32'd0);
    chk("rst_db4", 32'(db4), 32'd0);
    chk("rst_rdy4", 32'(rdy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'(!INIT_BUILD));
    chk("rst_e8", 32'(e8), 32'd0);
    chk("rst_db8", 32'(db8), 32'd0);
    chk("rst_rdy8", 32'(rdy8), 32'd0);
    rst_n = 1'b1;
`ifdef LCD_INIT_EN
    init_check("init");
`else
    @(negedge clk);
    chk("rdy4_after_rst", 32'(rdy4), 32'd1);
    chk("rdy8_after_rst", 32'(rdy8), 32'd1);
`endif

    xfer4("d41", 1'b1, 8'h41, 1'b0, 6);
    xfer4("c01", 1'b0, 8'h01, 1'b0, 15);
    xfer4("c80", 1'b0, 8'h80, 1'b0, 6);
    xfer4("poke", 1'b1, 8'h41, 1'b1, 6);
    xfer8("c38", 1'b0, 8'h38, 6);
    xfer8("c01_8", 1'b0, 8'h01, 15);

    // Reset while lcd_e is high aborts the byte.
    @(negedge clk);
    clr_q();
    rs_i = 1'b1; data_i = 8'h41; v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (e4) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_pulse_seen", 32'(seen), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_e4", 32'(e4), 32'd0);
    chk("abort_db4", 32'(db4), 32'd0);
    chk("abort_rs4", 32'(rs4), 32'd0);
    chk("abort_rdy4", 32'(rdy4), 32'd0);
    chk("abort_done4", 32'(done4), 32'(!INIT_BUILD));
    rst_n = 1'b1;
    @(negedge clk);
    clr_q();
`ifdef LCD_INIT_EN
    init_check("reinit");
`else
    repeat (40) @(negedge clk);
    chk("abort_no_strobe", 32'(r4_q.size()), 32'd0);
    chk("abort_rdy_back", 32'(rdy4), 32'd1);
`endif

    chk("rw_low", 32'(rw_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
